// File: rtl/quant_dot_mac.sv
// Streaming dot-product MAC: unsigned activations x signed weights, VEC_LEN
// products accumulated into one signed result. The result is returned through
// a valid/ready output handshake, and the accumulator can clamp or wrap.
module quant_dot_mac #(
  parameter int unsigned X_W      = 2,
  parameter int unsigned W_W      = 2,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned VEC_LEN  = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  input  logic [W_W-1:0]   in_w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned PROD_W = X_W + W_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic signed [PROD_W-1:0] x_ext_c, w_ext_c, prod_c;
  logic [SUM_W-1:0]         sum_c;
  logic                     add_ovf_c;
  logic [ACC_W-1:0]         add_res_c;
  logic                     accept_c;

  // Signed product: activation zero-extended, weight sign-extended
  assign x_ext_c = signed'(PROD_W'(in_x));
  assign w_ext_c = PROD_W'($signed(in_w));
  assign prod_c  = x_ext_c * w_ext_c;

  // One-bit-wider add so overflow shows up as disagreeing top bits
  assign sum_c     = {acc_q[ACC_W-1], acc_q}
                   + {{(SUM_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
  assign add_ovf_c = sum_c[ACC_W] ^ sum_c[ACC_W-1];
  assign add_res_c = (add_ovf_c && SATURATE) ? (sum_c[ACC_W] ? ACC_MIN : ACC_MAX)
                                             : sum_c[ACC_W-1:0];

  assign accept_c = (state_q == ST_ACC) && in_valid;

  // Next-state and datapath updates for the ACC/DRAIN/HOLD sequence
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      ST_ACC: begin
        pend_d = accept_c;
        if (pend_q) begin
          acc_d = add_res_c;
          ovf_d = ovf_q | add_ovf_c;
        end
        if (accept_c) begin
          prod_d = prod_c;
          if (count_q == CNT_LAST) begin
            count_d = '0;
            state_d = ST_DRAIN;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pend_q) begin
          acc_d = add_res_c;
          ovf_d = ovf_q | add_ovf_c;
        end
        pend_d  = 1'b0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_HOLD);
  end

  // State and datapath registers; reset discards any partial vector
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      count_q     <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule
